ex_mem_stage: RTL and testbench

Pipeline register and branch-resolution stage directly downstream of the ALU. It captures the execute-stage result (ALUResult) together with the memory and write-back control bits, and decides whether a branch or jump is taken. On a taken branch or jump it issues a one-cycle PC redirect and converts the wrong-path instructions that follow into bubbles. Its outputs feed the data-memory stage and the fetch PC mux.

---
 rtl/ex_mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX/MEM pipeline register with branch resolution. It captures the ALU
//   result plus the memory and write-back control bits. It also decides
//   whether a branch or jump is taken. A taken branch or jump produces a
//   one-cycle PC redirect (pc_sel/pc_target). The following SQUASH_CYCLES
//   accepted instructions are then turned into bubbles.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               hold all state, the presented instruction is not consumed
//   flush               register a bubble and abort any squash in progress
//   in_valid            EX instruction present
//   ALUResult           ALU output, bit 0 is the branch compare result
//   PC, Imm             instruction byte address and scaled sign-extended offset
//   StoreData, Rd       store value and destination register
//   RegWrite..Jump      decode control bits
//   out_*               registered instruction fields, control masked by out_valid
//   pc_sel, pc_target   one-cycle redirect request and its address
//   squashing           high while wrong-path instructions are being discarded
module ex_mem_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int SQUASH_CYCLES  = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall,
   input  logic                      flush,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     ALUResult,
   input  logic [DATA_WIDTH-1:0]     PC,
   input  logic [DATA_WIDTH-1:0]     Imm,
   input  logic [DATA_WIDTH-1:0]     StoreData,
   input  logic [REG_ADDR_WIDTH-1:0] Rd,
   input  logic                      RegWrite,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic                      MemtoReg,
   input  logic                      Branch,
   input  logic                      Jump,
   output logic                      out_valid,
   output logic [DATA_WIDTH-1:0]     out_result,
   output logic [DATA_WIDTH-1:0]     out_store_data,
   output logic [REG_ADDR_WIDTH-1:0] out_rd,
   output logic                      out_reg_write,
   output logic                      out_mem_read,
   output logic                      out_mem_write,
   output logic                      out_memto_reg,
   output logic                      pc_sel,
   output logic [DATA_WIDTH-1:0]     pc_target,
   output logic                      squashing
);

   typedef enum logic {
      IDLE   = 1'b0,
      SQUASH = 1'b1
   } state_e;

   localparam logic [DATA_WIDTH-1:0] LINK_OFS  = DATA_WIDTH'(32'd4);
   localparam logic [2:0]            CNT_LOAD  = 3'(SQUASH_CYCLES);

   state_e                    state_q, state_d;
   logic [2:0]                cnt_q, cnt_d;
   logic                      valid_q, valid_d;
   logic [DATA_WIDTH-1:0]     result_q, result_d;
   logic [DATA_WIDTH-1:0]     store_data_q, store_data_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
   logic                      reg_write_q, reg_write_d;
   logic                      mem_read_q, mem_read_d;
   logic                      mem_write_q, mem_write_d;
   logic                      memto_reg_q, memto_reg_d;
   logic                      pc_sel_q, pc_sel_d;
   logic [DATA_WIDTH-1:0]     pc_target_q, pc_target_d;
   logic                      squashing_q, squashing_d;

   logic eff_v;
   logic take;

   // Wrong-path instructions arriving during SQUASH are never valid and cannot redirect.
   always_comb begin
      eff_v = in_valid & (state_q != SQUASH);
      take  = eff_v & (Jump | (Branch & ALUResult[0]));
   end

   // Next-state computation: flush beats stall beats a normal load.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      result_d     = result_q;
      store_data_d = store_data_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      memto_reg_d  = memto_reg_q;
      pc_sel_d     = 1'b0;          // redirect is a single pulse, never held by stall
      pc_target_d  = pc_target_q;

      if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         memto_reg_d = 1'b0;
         state_d     = IDLE;
         cnt_d       = 3'd0;
      end else if (stall) begin
         state_d = state_q;
      end else begin
         valid_d      = eff_v;
         result_d     = Jump ? (PC + LINK_OFS) : ALUResult;
         store_data_d = StoreData;
         rd_d         = Rd;
         reg_write_d  = RegWrite & eff_v;
         mem_read_d   = MemRead  & eff_v;
         mem_write_d  = MemWrite & eff_v;
         memto_reg_d  = MemtoReg & eff_v;

         case (state_q)
            IDLE: begin
               if (take) begin
                  pc_sel_d    = 1'b1;
                  pc_target_d = PC + Imm;
                  state_d     = SQUASH;
                  cnt_d       = CNT_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            SQUASH: begin
               // Every consumed slot counts, whether or not it carried an instruction.
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = IDLE;
               end else begin
                  state_d = SQUASH;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end

      squashing_d = (state_d == SQUASH);
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         valid_q      <= 1'b0;
         result_q     <= '0;
         store_data_q <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         memto_reg_q  <= 1'b0;
         pc_sel_q     <= 1'b0;
         pc_target_q  <= '0;
         squashing_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_q      <= valid_d;
         result_q     <= result_d;
         store_data_q <= store_data_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         memto_reg_q  <= memto_reg_d;
         pc_sel_q     <= pc_sel_d;
         pc_target_q  <= pc_target_d;
         squashing_q  <= squashing_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_result     = result_q;
   assign out_store_data = store_data_q;
   assign out_rd         = rd_q;
   assign out_reg_write  = reg_write_q;
   assign out_mem_read   = mem_read_q;
   assign out_mem_write  = mem_write_q;
   assign out_memto_reg  = memto_reg_q;
   assign pc_sel         = pc_sel_q;
   assign pc_target      = pc_target_q;
   assign squashing      = squashing_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
//   Directed bench for ex_mem_stage. Each step drives the inputs, waits for
//   one rising edge and compares the outputs with hand-computed values.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid;
   logic [31:0] ALUResult, PC, Imm, StoreData;
   logic [4:0]  Rd;
   logic        RegWrite, MemRead, MemWrite, MemtoReg, Branch, Jump;
   logic        out_valid, out_reg_write, out_mem_read, out_mem_write, out_memto_reg;
   logic [31:0] out_result, out_store_data, pc_target;
   logic [4:0]  out_rd;
   logic        pc_sel, squashing;

   int tests_run = 0;
   int tests_failed = 0;

   ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SQUASH_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .ALUResult(ALUResult), .PC(PC), .Imm(Imm), .StoreData(StoreData), .Rd(Rd),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .Branch(Branch), .Jump(Jump),
      .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
      .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_memto_reg(out_memto_reg),
      .pc_sel(pc_sel), .pc_target(pc_target), .squashing(squashing)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      in_valid = 1'b0; ALUResult = 32'h0; PC = 32'h0; Imm = 32'h0; StoreData = 32'h0;
      Rd = 5'd0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0;
      Branch = 1'b0; Jump = 1'b0; stall = 1'b0; flush = 1'b0;
   endtask

   // Present a plain valid instruction with RegWrite set.
   task automatic alu_op(input logic [31:0] res, input logic [4:0] rd);
      clear_in();
      in_valid = 1'b1; ALUResult = res; Rd = rd; RegWrite = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_in();
      reset = 1'b1;
      in_valid = 1'b1; RegWrite = 1'b1; ALUResult = 32'h55; Rd = 5'd3;
      tick(); tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_regwr", 32'(out_reg_write), 32'd0);
      check("rst_pcsel", 32'(pc_sel), 32'd0);
      check("rst_squash", 32'(squashing), 32'd0);
      check("rst_result", out_result, 32'h0);
      check("rst_target", pc_target, 32'h0);
      check("rst_rd", 32'(out_rd), 32'd0);
      reset = 1'b0;

      // plain ALU op
      alu_op(32'h0000_0015, 5'd5);
      tick();
      check("alu_valid", 32'(out_valid), 32'd1);
      check("alu_result", out_result, 32'h15);
      check("alu_rd", 32'(out_rd), 32'd5);
      check("alu_regwr", 32'(out_reg_write), 32'd1);
      check("alu_pcsel", 32'(pc_sel), 32'd0);

      // store and load control bits pass through
      clear_in();
      in_valid = 1'b1; MemWrite = 1'b1; StoreData = 32'hDEAD_BEEF; ALUResult = 32'h80;
      tick();
      check("st_memwr", 32'(out_mem_write), 32'd1);
      check("st_data", out_store_data, 32'hDEAD_BEEF);
      check("st_memrd", 32'(out_mem_read), 32'd0);
      clear_in();
      in_valid = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; Rd = 5'd9;
      tick();
      check("ld_memrd", 32'(out_mem_read), 32'd1);
      check("ld_m2r", 32'(out_memto_reg), 32'd1);
      check("ld_memwr", 32'(out_mem_write), 32'd0);

      // taken BEQ, target wraps below PC
      clear_in();
      in_valid = 1'b1; PC = 32'h100; Imm = 32'hFFFF_FFF0; Branch = 1'b1; ALUResult = 32'h1;
      tick();
      check("beq_pcsel", 32'(pc_sel), 32'd1);
      check("beq_target", pc_target, 32'hF0);
      check("beq_squash", 32'(squashing), 32'd1);
      check("beq_valid", 32'(out_valid), 32'd1);
      alu_op(32'hA1, 5'd1);
      tick();
      check("sq1_valid", 32'(out_valid), 32'd0);
      check("sq1_regwr", 32'(out_reg_write), 32'd0);
      check("sq1_pcsel", 32'(pc_sel), 32'd0);
      check("sq1_squash", 32'(squashing), 32'd1);
      // wrong-path jump: bubble, no redirect
      alu_op(32'hB2, 5'd2); Jump = 1'b1; PC = 32'h300; Imm = 32'h20;
      tick();
      check("sq2_valid", 32'(out_valid), 32'd0);
      check("sq2_regwr", 32'(out_reg_write), 32'd0);
      check("sq2_pcsel", 32'(pc_sel), 32'd0);
      check("sq2_squash", 32'(squashing), 32'd0);
      check("sq2_target", pc_target, 32'hF0);
      alu_op(32'hC3, 5'd3);
      tick();
      check("post_valid", 32'(out_valid), 32'd1);
      check("post_regwr", 32'(out_reg_write), 32'd1);
      check("post_result", out_result, 32'hC3);

      // not-taken BNE
      clear_in();
      in_valid = 1'b1; PC = 32'h400; Imm = 32'h10; Branch = 1'b1; ALUResult = 32'h0;
      tick();
      check("bne_pcsel", 32'(pc_sel), 32'd0);
      check("bne_squash", 32'(squashing), 32'd0);
      check("bne_valid", 32'(out_valid), 32'd1);
      check("bne_target", pc_target, 32'hF0);

      // JAL with wrap on both link and target
      clear_in();
      in_valid = 1'b1; PC = 32'hFFFF_FFFC; Imm = 32'h8; Jump = 1'b1; RegWrite = 1'b1;
      ALUResult = 32'h1234; Rd = 5'd1;
      tick();
      check("jal_result", out_result, 32'h0);
      check("jal_target", pc_target, 32'h4);
      check("jal_pcsel", 32'(pc_sel), 32'd1);
      check("jal_regwr", 32'(out_reg_write), 32'd1);
      clear_in();
      tick();
      check("jal_sq1", 32'(squashing), 32'd1);
      tick();
      check("jal_sq2", 32'(squashing), 32'd0);

      // stall for 3 cycles right after the redirect
      clear_in();
      in_valid = 1'b1; PC = 32'h200; Imm = 32'h40; Branch = 1'b1; ALUResult = 32'h1;
      tick();
      check("stb_pcsel", 32'(pc_sel), 32'd1);
      check("stb_target", pc_target, 32'h240);
      alu_op(32'hE1, 5'd7); stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stl_pcsel", 32'(pc_sel), 32'd0);
         check("stl_squash", 32'(squashing), 32'd1);
         check("stl_valid", 32'(out_valid), 32'd1);
         check("stl_result", out_result, 32'h1);
      end
      stall = 1'b0;
      tick();
      check("sts1_valid", 32'(out_valid), 32'd0);
      check("sts1_squash", 32'(squashing), 32'd1);
      tick();
      check("sts2_valid", 32'(out_valid), 32'd0);
      check("sts2_squash", 32'(squashing), 32'd0);
      tick();
      check("sts3_valid", 32'(out_valid), 32'd1);
      check("sts3_result", out_result, 32'hE1);

      // flush on the same edge as a taken jump
      clear_in();
      in_valid = 1'b1; PC = 32'h500; Imm = 32'h100; Jump = 1'b1; RegWrite = 1'b1; flush = 1'b1;
      tick();
      check("fl_pcsel", 32'(pc_sel), 32'd0);
      check("fl_valid", 32'(out_valid), 32'd0);
      check("fl_regwr", 32'(out_reg_write), 32'd0);
      check("fl_squash", 32'(squashing), 32'd0);
      alu_op(32'h77, 5'd4);
      tick();
      check("flp_valid", 32'(out_valid), 32'd1);
      check("flp_result", out_result, 32'h77);

      // flush mid-squash, with stall also asserted
      clear_in();
      in_valid = 1'b1; PC = 32'h600; Imm = 32'h8; Branch = 1'b1; ALUResult = 32'h1;
      tick();
      check("fm_pcsel0", 32'(pc_sel), 32'd1);
      alu_op(32'h88, 5'd6); flush = 1'b1; stall = 1'b1;
      tick();
      check("fm_pcsel", 32'(pc_sel), 32'd0);
      check("fm_valid", 32'(out_valid), 32'd0);
      check("fm_squash", 32'(squashing), 32'd0);
      alu_op(32'h99, 5'd8);
      tick();
      check("fmp_valid", 32'(out_valid), 32'd1);
      check("fmp_regwr", 32'(out_reg_write), 32'd1);
      check("fmp_pcsel", 32'(pc_sel), 32'd0);

      // reset mid-squash
      clear_in();
      in_valid = 1'b1; PC = 32'h700; Imm = 32'h4; Jump = 1'b1;
      tick();
      check("rm_pcsel", 32'(pc_sel), 32'd1);
      alu_op(32'hAA, 5'd9); reset = 1'b1;
      tick();
      check("rm_squash", 32'(squashing), 32'd0);
      check("rm_valid", 32'(out_valid), 32'd0);
      check("rm_target", pc_target, 32'h0);
      reset = 1'b0;
      tick();
      check("rmp_valid", 32'(out_valid), 32'd1);
      check("rmp_result", out_result, 32'hAA);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
